// File: rtl/fixed_divide.sv
// ---------------------------------------------------------------------------
// fixed_divide
//
// Signed fixed-point divider for the ray-tracer datapath. Computes
//   quotient = (dividend << Q_BITS) / divisor
// truncated toward zero. A fully pipelined restoring-division array accepts
// one operand pair per clock. Results come back in input order after
// ED_WIDTH+2 clocks.
//
// Ports:
//   clock        in   1        rising-edge clock
//   reset        in   1        synchronous, active-high; drops all in-flight work
//   dividend     in   D_WIDTH  signed fixed-point numerator
//   divisor      in   D_WIDTH  signed fixed-point denominator
//   valid_in     in   1        operands valid this cycle
//   quotient     out  D_WIDTH  signed fixed-point result (held while idle)
//   valid_out    out  1        one-cycle pulse per accepted input
//   div_by_zero  out  1        only with DIVIDE_DBZ_FLAG_EN: result had divisor 0
//
// Optional build macro:
//   DIVIDE_DBZ_FLAG_EN  adds the div_by_zero output. Saturation on divide by
//                       zero is the same whether or not the macro is defined.
//
// Pipeline layout (register stages):
//   0             operand capture: sign, magnitudes, divide-by-zero
//   1..ED_WIDTH   one restoring-division step per stage, numerator MSB first
//   ED_WIDTH+1    saturation decision and conditional negation
//   ED_WIDTH+2    output register (quotient / valid_out)
// ---------------------------------------------------------------------------
module fixed_divide #(
    parameter int Q_BITS   = 10,
    parameter int D_WIDTH  = 32,
    parameter int ED_WIDTH = D_WIDTH + Q_BITS + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    input  logic               valid_in,
    output logic [D_WIDTH-1:0] quotient,
    output logic               valid_out
`ifdef DIVIDE_DBZ_FLAG_EN
    ,
    output logic               div_by_zero
`endif
);

    // Saturation limits, both in the expanded magnitude width and in the
    // output width.
    localparam logic [ED_WIDTH-1:0] POS_LIMIT =
        {{(ED_WIDTH-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic [ED_WIDTH-1:0] NEG_LIMIT = POS_LIMIT + 1'b1;
    localparam logic [D_WIDTH-1:0]  MAX_POS   = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0]  MIN_NEG   = {1'b1, {(D_WIDTH-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Operand conditioning (feeds stage 0)
    // -----------------------------------------------------------------------
    logic [D_WIDTH-1:0]  mag_dividend;
    logic [D_WIDTH-1:0]  mag_divisor;
    logic [ED_WIDTH-1:0] ext_dividend;
    logic [ED_WIDTH-1:0] ext_divisor;

    // Negating -2^(D_WIDTH-1) wraps back to 100..0. That pattern, read as
    // unsigned, is exactly 2^(D_WIDTH-1), so the magnitude is still correct.
    always_comb begin
        mag_dividend = dividend[D_WIDTH-1] ? (~dividend + 1'b1) : dividend;
        mag_divisor  = divisor[D_WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        ext_dividend = {{(ED_WIDTH-D_WIDTH){1'b0}}, mag_dividend};
        ext_divisor  = {{(ED_WIDTH-D_WIDTH){1'b0}}, mag_divisor};
    end

    // -----------------------------------------------------------------------
    // Division array state. Index k holds what stage k registered.
    // Remainder, numerator and divisor are only needed as inputs to a later
    // step, so the last division stage keeps only its quotient.
    // -----------------------------------------------------------------------
    logic [ED_WIDTH-1:0] rem_q [0:ED_WIDTH-1];
    logic [ED_WIDTH-1:0] num_q [0:ED_WIDTH-1];
    logic [ED_WIDTH-1:0] den_q [0:ED_WIDTH-1];
    logic [ED_WIDTH-1:0] quo_q [0:ED_WIDTH];

    // Per-operation sidebands travel as packed shift registers.
    // vld_q carries one extra bit for the saturation stage.
    logic [ED_WIDTH+1:0] vld_q;
    logic [ED_WIDTH:0]   sign_q;
    logic [ED_WIDTH:0]   dbz_q;

    // Combinational step for each division stage.
    logic [ED_WIDTH-1:0] trial     [1:ED_WIDTH];
    logic                trial_ge  [1:ED_WIDTH];
    logic [ED_WIDTH-1:0] trial_rem [1:ED_WIDTH];

    always_comb begin
        for (int unsigned k = 1; k <= ED_WIDTH; k++) begin
            trial[k]     = {rem_q[k-1][ED_WIDTH-2:0], num_q[k-1][ED_WIDTH-1]};
            trial_ge[k]  = (trial[k] >= den_q[k-1]);
            trial_rem[k] = trial_ge[k] ? (trial[k] - den_q[k-1]) : trial[k];
        end
    end

    // Valid bits are the only pipeline state that has to be reset. Clearing
    // them is enough to discard every operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[ED_WIDTH:0], valid_in};
        end
    end

    always_ff @(posedge clock) begin
        // Stage 0: operand capture. N = |dividend| << Q_BITS fits in
        // ED_WIDTH bits because ED_WIDTH = D_WIDTH + Q_BITS + 1.
        rem_q[0] <= '0;
        quo_q[0] <= '0;
        num_q[0] <= ext_dividend << Q_BITS;
        den_q[0] <= ext_divisor;
        sign_q   <= {sign_q[ED_WIDTH-1:0], dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1]};
        dbz_q    <= {dbz_q[ED_WIDTH-1:0], (divisor == '0)};

        // Stages 1..ED_WIDTH: restoring division steps.
        for (int unsigned k = 1; k <= ED_WIDTH; k++) begin
            quo_q[k] <= {quo_q[k-1][ED_WIDTH-2:0], trial_ge[k]};
            if (k < ED_WIDTH) begin
                rem_q[k] <= trial_rem[k];
                num_q[k] <= num_q[k-1] << 1;
                den_q[k] <= den_q[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Saturation stage: decide overflow against the full-width magnitude,
    // then negate the truncated value. A zero magnitude negates to +0.
    // -----------------------------------------------------------------------
    logic               sat_dbz;
    logic               sat_sign;
    logic               sat_pos_ovf;
    logic               sat_neg_ovf;
    logic [D_WIDTH-1:0] sat_val;

    always_ff @(posedge clock) begin
        sat_dbz     <= dbz_q[ED_WIDTH];
        sat_sign    <= sign_q[ED_WIDTH];
        sat_pos_ovf <= !sign_q[ED_WIDTH] && (quo_q[ED_WIDTH] > POS_LIMIT);
        sat_neg_ovf <=  sign_q[ED_WIDTH] && (quo_q[ED_WIDTH] > NEG_LIMIT);
        sat_val     <= sign_q[ED_WIDTH] ? (~quo_q[ED_WIDTH][D_WIDTH-1:0] + 1'b1)
                                        : quo_q[ED_WIDTH][D_WIDTH-1:0];
    end

    // -----------------------------------------------------------------------
    // Output register. quotient updates only when a result lands, so it
    // holds its last value between results.
    // -----------------------------------------------------------------------
    logic [D_WIDTH-1:0] result;

    // With a zero divisor the captured sign equals the dividend sign, which
    // picks the saturation direction. That includes a zero dividend (+max).
    always_comb begin
        result = sat_val;
        if (sat_dbz) begin
            result = sat_sign ? MIN_NEG : MAX_POS;
        end else if (sat_pos_ovf) begin
            result = MAX_POS;
        end else if (sat_neg_ovf) begin
            result = MIN_NEG;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_out <= 1'b0;
            quotient  <= '0;
        end else begin
            valid_out <= vld_q[ED_WIDTH+1];
            if (vld_q[ED_WIDTH+1]) begin
                quotient <= result;
            end
        end
    end

`ifdef DIVIDE_DBZ_FLAG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= vld_q[ED_WIDTH+1] && sat_dbz;
        end
    end
`endif

endmodule

// File: tb/tb_fixed_divide.sv
module tb_fixed_divide;

    localparam int Q_BITS   = 10;
    localparam int D_WIDTH  = 32;
    localparam int ED_WIDTH = D_WIDTH + Q_BITS + 1;
    localparam int LATENCY  = ED_WIDTH + 2;
    localparam int BUDGET   = 80;

    logic               clock;
    logic               reset;
    logic [D_WIDTH-1:0] dividend;
    logic [D_WIDTH-1:0] divisor;
    logic               valid_in;
    logic [D_WIDTH-1:0] quotient;
    logic               valid_out;
    logic               dbz_flag;

    int tests_run = 0;
    int tests_failed = 0;

    fixed_divide #(
        .Q_BITS  (Q_BITS),
        .D_WIDTH (D_WIDTH),
        .ED_WIDTH(ED_WIDTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .dividend (dividend),
        .divisor  (divisor),
        .valid_in (valid_in),
        .quotient (quotient),
        .valid_out(valid_out)
`ifdef DIVIDE_DBZ_FLAG_EN
        ,
        .div_by_zero(dbz_flag)
`endif
    );

`ifndef DIVIDE_DBZ_FLAG_EN
    assign dbz_flag = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string              name;
        logic [D_WIDTH-1:0] a;
        logic [D_WIDTH-1:0] b;
        logic [D_WIDTH-1:0] exp;
        logic               dbz;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits on negedges until valid_out rises, returning the number of
    // clock edges since the sampling edge (or BUDGET on timeout).
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!valid_out && cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    // One single-cycle input, then wait for its result.
    task automatic run_single(input string name, input logic [D_WIDTH-1:0] a,
                              input logic [D_WIDTH-1:0] b, input logic [D_WIDTH-1:0] exp,
                              input logic dbz);
        int cyc;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        valid_in = 1'b1;
        @(negedge clock);
        valid_in = 1'b0;
        wait_result(cyc);
        check({name, " latency"}, 64'(cyc), 64'(LATENCY));
        check({name, " quotient"}, 64'(quotient), 64'(exp));
`ifdef DIVIDE_DBZ_FLAG_EN
        check({name, " dbz flag"}, 64'(dbz_flag), 64'(dbz));
`endif
        @(negedge clock);
        check({name, " pulse width"}, 64'(valid_out), 64'd0);
    endtask

    initial begin
        int cyc;
        int spurious;
        logic [D_WIDTH-1:0] held;

        vecs[0] = '{"mixed 190/-7",   32'h0002_F800, 32'hFFFF_E400, 32'hFFFF_936E, 1'b0};
        vecs[1] = '{"frac 1/4",       32'd1024,      32'd4096,      32'd256,       1'b0};
        vecs[2] = '{"neg -10/-4",     32'hFFFF_D800, 32'hFFFF_F000, 32'd2560,      1'b0};
        vecs[3] = '{"dbz 5/0",        32'd5120,      32'd0,         32'h7FFF_FFFF, 1'b1};
        vecs[4] = '{"dbz -5/0",       32'hFFFF_EC00, 32'd0,         32'h8000_0000, 1'b1};
        vecs[5] = '{"dbz 0/0",        32'd0,         32'd0,         32'h7FFF_FFFF, 1'b1};
        vecs[6] = '{"ovf max/1",      32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0};
        vecs[7] = '{"ovf min/1",      32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
        vecs[8] = '{"zero -0/3",      32'd0,         32'hFFFF_F400, 32'd0,         1'b0};

        reset    = 1'b1;
        dividend = '0;
        divisor  = '0;
        valid_in = 1'b0;
        repeat (3) @(negedge clock);
        check("reset valid_out", 64'(valid_out), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset dbz flag", 64'(dbz_flag), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_single(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dbz);
        end

        // quotient holds the last result while idle (last vector gave 0,
        // so load a non-zero one first).
        run_single("hold prep", 32'd1024, 32'd4096, 32'd256, 1'b0);
        repeat (5) @(negedge clock);
        check("hold quotient", 64'(quotient), 64'd256);

        // Continuous input with constant operands.
        @(negedge clock);
        dividend = 32'h0002_F800;
        divisor  = 32'hFFFF_E400;
        valid_in = 1'b1;
        @(negedge clock);
        wait_result(cyc);
        check("stream latency", 64'(cyc), 64'(LATENCY));
        for (int i = 0; i < 6; i++) begin
            check("stream valid", 64'(valid_out), 64'd1);
            check("stream quotient", 64'(quotient), 64'hFFFF_936E);
            @(negedge clock);
        end
        valid_in = 1'b0;
        repeat (LATENCY + 5) @(negedge clock);
        check("stream drained", 64'(valid_out), 64'd0);

        // Three back-to-back inputs come out in order on consecutive cycles.
        @(negedge clock);
        dividend = 32'h0002_F800; divisor = 32'hFFFF_E400; valid_in = 1'b1;
        @(negedge clock);
        dividend = 32'd1024;      divisor = 32'd4096;
        @(negedge clock);
        dividend = 32'd5120;      divisor = 32'd0;
        @(negedge clock);
        valid_in = 1'b0;
        cyc = 2;
        while (!valid_out && cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
        end
        check("b2b latency", 64'(cyc), 64'(LATENCY));
        check("b2b q0", 64'(quotient), 64'hFFFF_936E);
        @(negedge clock);
        check("b2b v1", 64'(valid_out), 64'd1);
        check("b2b q1", 64'(quotient), 64'd256);
        @(negedge clock);
        check("b2b v2", 64'(valid_out), 64'd1);
        check("b2b q2", 64'(quotient), 64'h7FFF_FFFF);
        @(negedge clock);
        check("b2b end", 64'(valid_out), 64'd0);

        // Reset mid-flight discards the in-flight operation.
        @(negedge clock);
        dividend = 32'd1024; divisor = 32'd4096; valid_in = 1'b1;
        @(negedge clock);
        valid_in = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        spurious = 0;
        for (int i = 0; i < LATENCY + 10; i++) begin
            if (valid_out) spurious++;
            @(negedge clock);
        end
        check("reset flush valid", 64'(spurious), 64'd0);
        check("reset flush quotient", 64'(quotient), 64'd0);

        run_single("after reset", 32'hFFFF_D800, 32'hFFFF_F000, 32'd2560, 1'b0);

        held = quotient;
        repeat (3) @(negedge clock);
        check("final hold", 64'(quotient), 64'(held == 32'd2560 ? 32'd2560 : 32'hDEAD_BEEF));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
